// File: rtl/bit_string_sender.sv
// bit_string_sender: takes one byte over a valid/ready handshake and sends it
// to a byte-wide UART transmitter as ASCII '0'/'1' characters, optionally
// followed by CR LF. A one-entry holding register lets the producer queue the
// next byte while the current frame is still being sent.
module bit_string_sender #(
   parameter bit TERMINATE = 1'b1,   // 1: append CR LF after the 8 bit characters
   parameter bit LSB_FIRST = 1'b0    // 1: bit 0 goes out first
) (
   input  logic       clk,
   input  logic       rst,           // synchronous, active low
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic [7:0] tx_data,
   output logic       new_tx_data,
   input  logic       tx_busy,
   output logic       busy,
   output logic [7:0] frames_sent
);

   // Index of the final character of a frame: LF (9) or the eighth bit (7).
   localparam logic [3:0] LAST_IDX = TERMINATE ? 4'd9 : 4'd7;
   localparam logic [7:0] CHAR_0   = 8'h30;
   localparam logic [7:0] CHAR_1   = 8'h31;
   localparam logic [7:0] CHAR_CR  = 8'h0D;
   localparam logic [7:0] CHAR_LF  = 8'h0A;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,   // waiting for the UART to be free, then strobes
      GAP  = 2'd2    // the strobe cycle; guarantees a spacer between strobes
   } state_t;

   state_t     state;
   state_t     state_next;

   logic [7:0] hold;
   logic       hold_full;
   logic [7:0] work;
   logic [3:0] idx;

   logic       accept;
   logic       load;
   logic       emit;
   logic       last_char;
   logic       sel_bit;
   logic [7:0] char;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: IDLE waits for a held byte, EMIT waits for the UART,
   // GAP either loops back for the next character or closes the frame.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (hold_full) begin
               state_next = EMIT;
            end
         end
         EMIT: begin
            if (!tx_busy) begin
               state_next = GAP;
            end
         end
         GAP: begin
            if (idx == LAST_IDX) begin
               state_next = IDLE;
            end else begin
               state_next = EMIT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output and control decode; the character is chosen from idx and the
   // end of the shift register that faces the wire.
   always_comb begin
      byte_ready = !hold_full;
      busy       = (state != IDLE);
      accept     = byte_valid && !hold_full;
      load       = (state == IDLE) && hold_full;
      emit       = (state == EMIT) && !tx_busy;
      last_char  = (state == GAP) && (idx == LAST_IDX);
      sel_bit    = LSB_FIRST ? work[0] : work[7];
      char       = sel_bit ? CHAR_1 : CHAR_0;
      if (idx == 4'd8) begin
         char = CHAR_CR;
      end else if (idx == 4'd9) begin
         char = CHAR_LF;
      end
   end

   // Holding register: filled by the handshake, emptied when IDLE takes it.
   // Both cannot happen in one cycle because byte_ready is low while full.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hold      <= 8'h00;
         hold_full <= 1'b0;
      end else if (accept) begin
         hold      <= byte_in;
         hold_full <= 1'b1;
      end else if (load) begin
         hold_full <= 1'b0;
      end
   end

   // Working shift register and character index.
   always_ff @(posedge clk) begin
      if (!rst) begin
         work <= 8'h00;
         idx  <= 4'd0;
      end else if (load) begin
         work <= hold;
         idx  <= 4'd0;
      end else if (emit) begin
         // Shift the next bit toward the selected end; harmless during CR/LF.
         work <= LSB_FIRST ? {1'b0, work[7:1]} : {work[6:0], 1'b0};
      end else if (state == GAP) begin
         idx <= idx + 4'd1;
      end
   end

   // Registered strobe, character and completed-frame counter.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_data     <= 8'h00;
         new_tx_data <= 1'b0;
         frames_sent <= 8'h00;
      end else begin
         new_tx_data <= emit;
         if (emit) begin
            tx_data <= char;
         end
         if (last_char) begin
            frames_sent <= frames_sent + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_bit_string_sender.sv
// Directed testbench for bit_string_sender. Instance dut_a uses the default
// parameters (MSB first, CR LF appended); dut_b is LSB first without CR LF.
module tb_bit_string_sender;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_busy;

   logic [7:0] byte_in_a;
   logic       byte_valid_a;
   logic       byte_ready_a;
   logic [7:0] tx_data_a;
   logic       new_tx_data_a;
   logic       busy_a;
   logic [7:0] frames_sent_a;

   logic [7:0] byte_in_b;
   logic       byte_valid_b;
   logic       byte_ready_b;
   logic [7:0] tx_data_b;
   logic       new_tx_data_b;
   logic       busy_b;
   logic [7:0] frames_sent_b;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   logic [7:0] qa[$];
   int         ta[$];
   logic [7:0] qb[$];
   bit         uart_mode = 1'b0;
   int         busy_cnt = 0;

   always #5 clk = ~clk;

   bit_string_sender dut_a (
      .clk         (clk),
      .rst         (rst),
      .byte_in     (byte_in_a),
      .byte_valid  (byte_valid_a),
      .byte_ready  (byte_ready_a),
      .tx_data     (tx_data_a),
      .new_tx_data (new_tx_data_a),
      .tx_busy     (tx_busy),
      .busy        (busy_a),
      .frames_sent (frames_sent_a)
   );

   bit_string_sender #(.TERMINATE(1'b0), .LSB_FIRST(1'b1)) dut_b (
      .clk         (clk),
      .rst         (rst),
      .byte_in     (byte_in_b),
      .byte_valid  (byte_valid_b),
      .byte_ready  (byte_ready_b),
      .tx_data     (tx_data_b),
      .new_tx_data (new_tx_data_b),
      .tx_busy     (tx_busy),
      .busy        (busy_b),
      .frames_sent (frames_sent_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock; capture strobes and, in UART mode, emulate tx_busy.
   task automatic step();
      logic busy_at_edge;
      busy_at_edge = tx_busy;
      @(posedge clk);
      cyc++;
      #1;
      if (new_tx_data_a) begin
         qa.push_back(tx_data_a);
         ta.push_back(cyc);
         $display("cycle %0d: dut_a strobe 0x%02h", cyc, tx_data_a);
         if (uart_mode) chk("no_strobe_while_busy", {31'd0, busy_at_edge}, 32'd0);
      end
      if (new_tx_data_b) qb.push_back(tx_data_b);
      if (uart_mode) begin
         if (new_tx_data_a) busy_cnt = 50;
         else if (busy_cnt > 0) busy_cnt--;
         tx_busy = (busy_cnt > 0);
      end
   endtask

   // Offer a byte to dut_a; n is the cycle number of the accepting edge.
   task automatic send_a(input logic [7:0] b, output int n);
      byte_in_a    = b;
      byte_valid_a = 1'b1;
      for (int k = 0; k < 100; k++) begin
         if (byte_ready_a) break;
         step();
      end
      chk("send_a_ready", {31'd0, byte_ready_a}, 32'd1);
      step();
      n = cyc;
      byte_valid_a = 1'b0;
   endtask

   initial begin
      int         n;
      int         bad;
      logic       rise;
      int         accepted;
      bit         saw_wrap;
      int         qb_at_wrap;
      logic [7:0] prev;
      logic       rdy_before;
      logic       vld_before;
      logic [7:0] exp_b5 [10];
      logic [7:0] exp_5a [10];
      logic [7:0] exp_96 [8];

      exp_b5 = '{8'h31, 8'h30, 8'h31, 8'h31, 8'h30, 8'h31, 8'h30, 8'h31, 8'h0D, 8'h0A};
      exp_5a = '{8'h30, 8'h31, 8'h30, 8'h31, 8'h31, 8'h30, 8'h31, 8'h30, 8'h0D, 8'h0A};
      exp_96 = '{8'h30, 8'h31, 8'h31, 8'h30, 8'h31, 8'h30, 8'h30, 8'h31};

      // Reset state
      rst = 1'b0; tx_busy = 1'b0;
      byte_in_a = 8'h00; byte_valid_a = 1'b0;
      byte_in_b = 8'h00; byte_valid_b = 1'b0;
      repeat (3) step();
      chk("rst_ready_a", {31'd0, byte_ready_a}, 32'd1);
      chk("rst_busy_a", {31'd0, busy_a}, 32'd0);
      chk("rst_strobe_a", {31'd0, new_tx_data_a}, 32'd0);
      chk("rst_txdata_a", {24'd0, tx_data_a}, 32'h00);
      chk("rst_frames_a", {24'd0, frames_sent_a}, 32'd0);
      chk("rst_ready_b", {31'd0, byte_ready_b}, 32'd1);
      chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
      rst = 1'b1;
      step();

      // 0xB5, MSB first with CR LF, strobes every 2 cycles from N+2
      qa.delete(); ta.delete();
      send_a(8'hB5, n);
      repeat (25) step();
      chk("b5_count", qa.size(), 32'd10);
      for (int i = 0; i < 10; i++) begin
         if (i < qa.size()) begin
            chk("b5_char", {24'd0, qa[i]}, {24'd0, exp_b5[i]});
            chk("b5_time", ta[i], n + 2 + 2 * i);
         end
      end
      chk("b5_frames", {24'd0, frames_sent_a}, 32'd1);
      chk("b5_busy", {31'd0, busy_a}, 32'd0);

      // 0x01 on the LSB-first, unterminated instance
      qb.delete();
      byte_in_b = 8'h01; byte_valid_b = 1'b1;
      step();
      byte_valid_b = 1'b0;
      repeat (25) step();
      chk("lsb_count", qb.size(), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < qb.size()) chk("lsb_char", {24'd0, qb[i]}, (i == 0) ? 32'h31 : 32'h30);
      end
      chk("lsb_frames", {24'd0, frames_sent_b}, 32'd1);

      // 0x5A with the UART holding tx_busy 50 cycles after each strobe
      qa.delete(); ta.delete();
      uart_mode = 1'b1;
      send_a(8'h5A, n);
      for (int k = 0; k < 1500; k++) begin
         if (qa.size() >= 10 && !busy_a) break;
         step();
      end
      chk("uart_count", qa.size(), 32'd10);
      for (int i = 0; i < 10; i++) begin
         if (i < qa.size()) chk("uart_char", {24'd0, qa[i]}, {24'd0, exp_5a[i]});
      end
      chk("uart_frames", {24'd0, frames_sent_a}, 32'd2);
      uart_mode = 1'b0; busy_cnt = 0; tx_busy = 1'b0;
      repeat (3) step();

      // Back-to-back 0xFF then 0x00 with byte_valid held high
      rst = 1'b0; step(); rst = 1'b1; step();
      qa.delete(); ta.delete();
      chk("b2b_ready0", {31'd0, byte_ready_a}, 32'd1);
      byte_in_a = 8'hFF; byte_valid_a = 1'b1;
      step();
      n = cyc;
      byte_in_a = 8'h00;
      step();
      chk("b2b_ready_n1", {31'd0, byte_ready_a}, 32'd1);
      step();
      byte_valid_a = 1'b0;
      chk("b2b_ready_n2", {31'd0, byte_ready_a}, 32'd0);
      bad = 0; rise = 1'b0;
      repeat (20) begin
         step();
         if (cyc <= n + 21) begin
            if (byte_ready_a) bad++;
         end else begin
            rise = byte_ready_a;
         end
      end
      chk("b2b_ready_low", bad, 32'd0);
      chk("b2b_ready_rise", {31'd0, rise}, 32'd1);
      repeat (25) step();
      chk("b2b_count", qa.size(), 32'd20);
      for (int i = 0; i < 20; i++) begin
         if (i < qa.size()) begin
            if (i % 10 == 8) chk("b2b_char", {24'd0, qa[i]}, 32'h0D);
            else if (i % 10 == 9) chk("b2b_char", {24'd0, qa[i]}, 32'h0A);
            else chk("b2b_char", {24'd0, qa[i]}, (i < 10) ? 32'h31 : 32'h30);
         end
      end
      chk("b2b_frames", {24'd0, frames_sent_a}, 32'd2);

      // Reset after the 4th strobe of a frame, with a byte held
      qa.delete(); ta.delete();
      send_a(8'hC3, n);
      send_a(8'h3C, n);
      for (int k = 0; k < 50; k++) begin
         if (qa.size() >= 4) break;
         step();
      end
      chk("mid_fourth", qa.size(), 32'd4);
      rst = 1'b0;
      step();
      chk("mid_strobe", {31'd0, new_tx_data_a}, 32'd0);
      chk("mid_busy", {31'd0, busy_a}, 32'd0);
      chk("mid_ready", {31'd0, byte_ready_a}, 32'd1);
      chk("mid_frames", {24'd0, frames_sent_a}, 32'd0);
      rst = 1'b1;
      qa.delete();
      repeat (40) step();
      chk("mid_silent", qa.size(), 32'd0);
      chk("mid_frames_after", {24'd0, frames_sent_a}, 32'd0);

      // 257 frames on dut_b: counter wraps after 256, frame 257 gives 1
      chk("wrap_start", {24'd0, frames_sent_b}, 32'd0);
      qb.delete();
      byte_in_b = 8'h96; byte_valid_b = 1'b1;
      accepted = 0; saw_wrap = 1'b0; qb_at_wrap = 0; prev = frames_sent_b;
      for (int k = 0; k < 6000; k++) begin
         if (accepted == 257) byte_valid_b = 1'b0;
         if (accepted == 257 && !busy_b && byte_ready_b) break;
         rdy_before = byte_ready_b;
         vld_before = byte_valid_b;
         step();
         if (vld_before && rdy_before) accepted++;
         if (prev == 8'd255 && frames_sent_b == 8'd0) begin
            saw_wrap   = 1'b1;
            qb_at_wrap = qb.size();
         end
         prev = frames_sent_b;
      end
      chk("wrap_accepted", accepted, 32'd257);
      chk("wrap_seen", {31'd0, saw_wrap}, 32'd1);
      chk("wrap_chars_at_wrap", qb_at_wrap, 32'd2048);
      chk("wrap_frames_257", {24'd0, frames_sent_b}, 32'd1);
      chk("wrap_total_chars", qb.size(), 32'd2056);
      for (int i = 0; i < 8; i++) begin
         if (2048 + i < qb.size()) chk("wrap_last_char", {24'd0, qb[2048 + i]}, {24'd0, exp_96[i]});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bit_string_sender.md
# bit_string_sender

Transmit-side counterpart of the bit-reversal message printer. It accepts one binary byte over a valid/ready handshake and sends it as ASCII '0'/'1' characters, optionally followed by CR LF, over the same `tx_data`/`new_tx_data`/`tx_busy` byte interface the UART transmitter uses. A one-entry holding register lets a producer queue the next byte while the current frame is still being sent. It sits between a byte producer (RAM reader, counter, test sequencer) and the UART TX.

## Interface
- `TERMINATE`, default 1: 1 = append CR (0x0D) and LF (0x0A) after the 8 bit characters; 0 = 8 characters only.
- `LSB_FIRST`, default 0: 0 = send bit 7 first; 1 = send bit 0 first.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-low reset.
- `byte_in` input 8: byte to send; sampled when `byte_valid && byte_ready`.
- `byte_valid` input 1: producer has a byte.
- `byte_ready` output 1: holding register empty; equals `!hold_full`.
- `tx_data` output 8: ASCII character to the UART; valid while `new_tx_data` is high.
- `new_tx_data` output 1: one-cycle, registered strobe, one per character.
- `tx_busy` input 1: UART busy; no strobe is issued while it is high.
- `busy` output 1: a frame is in progress (state is not IDLE).
- `frames_sent` output 8: count of completed frames; wraps 255 -> 0.

## Operation
- Registers:
  - `hold` (8 bits) + `hold_full`.
  - `work` shift register (8 bits).
  - `idx` (4 bits): 0-7 are bits, 8 is CR, 9 is LF.
  - `state`.
  - Registered `tx_data`, `new_tx_data`, `frames_sent`.
- Reset (`rst == 0` at an edge):
  - `state` = IDLE; `hold_full`, `idx`, `work`, `new_tx_data`, `frames_sent` = 0.
  - `tx_data` = 0x00; `hold` = 0x00.
  - Outputs after reset: `byte_ready` = 1, `busy` = 0.
  - Reset mid-frame drops the frame and any held byte. No further strobes are issued, and `frames_sent` does not increment.
- Accept: when `byte_valid && byte_ready`, `hold` <= `byte_in` and `hold_full` <= 1.
- IDLE:
  - If `hold_full`: `work` <= `hold`, `hold_full` <= 0, `idx` <= 0, go to EMIT.
  - Otherwise stay in IDLE.
- EMIT:
  - If `tx_busy == 0`: drive the current character. Register `new_tx_data` <= 1 and `tx_data` <= character, then go to GAP.
  - If `tx_busy == 1`: stay in EMIT. Hold as long as required; there is no timeout.
- Character for `idx` 0-7:
  - "1" (0x31) if the selected bit is 1, otherwise "0" (0x30).
  - The selected bit is `work[7]` when `LSB_FIRST == 0`, `work[0]` when `LSB_FIRST == 1`.
  - `work` shifts toward the selected end after each character.
- GAP (the strobe cycle):
  - `new_tx_data` <= 0; `idx` <= `idx` + 1.
  - Last character (`idx == 7` with `TERMINATE == 0`, or `idx == 9`): `frames_sent` <= `frames_sent` + 1, go to IDLE.
  - Otherwise go to EMIT.
- GAP guarantees at least one cycle between strobes, so the UART can raise `tx_busy` before EMIT samples it again.
- Simultaneous events:
  - An accept in the same cycle that IDLE empties `hold`: not possible, because `byte_ready` was 0 in that cycle.
  - While IDLE empties `hold`, `byte_ready` rises on the next cycle.
- `byte_ready` rises again only after IDLE moves the held byte into `work`, so at most two bytes are in flight: one in `work`, one in `hold`.

## Timing
- Byte accepted at edge N with the FSM in IDLE:
  - Edge N+1: IDLE -> EMIT.
  - First `new_tx_data` high in the cycle after edge N+2, when `tx_busy` is low at N+2.
- Back-to-back rate: one character per 2 cycles while `tx_busy` stays low.
  - Full frame with TERMINATE = 20 cycles; 16 cycles without.
- Frame-to-frame: after the last GAP, IDLE costs 1 cycle before the next EMIT if `hold_full`.
- `frames_sent` increments at the edge that ends the last GAP.
- `busy` falls at that same edge.

## Test plan
- Reset, then `byte_in` = 0xB5 (10110101), defaults, `tx_busy` held 0:
  - Strobes carry "1","0","1","1","0","1","0","1",0x0D,0x0A.
  - Strobes occur every 2 cycles, the first at N+2.
  - `frames_sent` = 1, `busy` = 0.
- `LSB_FIRST` = 1, `TERMINATE` = 0, `byte_in` = 0x01:
  - Sequence "1" followed by seven "0"s.
  - Exactly 8 strobes, no CR/LF.
- Assert `tx_busy` for 50 cycles after each strobe (emulating the UART):
  - Never a strobe while `tx_busy` = 1.
  - All 10 characters delivered in order.
- Offer 0xFF then 0x00 back-to-back with `byte_valid` held high:
  - Second byte is accepted into `hold` during frame 1.
  - A third byte sees `byte_ready` = 0 until frame 2 starts.
  - Output is ten characters for 0xFF then ten for 0x00; `frames_sent` = 2.
- Pull `rst` low after the 4th strobe of a frame, with a byte held:
  - Next cycle: `new_tx_data` = 0, `busy` = 0, `byte_ready` = 1, `frames_sent` = 0.
  - No strobes until a new byte is offered.
- Send 256 frames:
  - `frames_sent` wraps to 0.
  - Frame 257 increments it to 1.
